// File: rtl/uart_rx_module_if.sv
// Byte-side and line-side signals of the UART receiver.
// The slave modport is the receiver. The master modport drives the line and consumes bytes.
interface uart_rx_module_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_module.sv
// 8-N-1 UART receiver with a two-flop line synchroniser, start-glitch rejection and framing-error strobe.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the last three sample cycles.
module uart_rx_module #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_rx_module_if.slave  rx_if
);

  localparam int unsigned HALF     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(HALF - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shifter_q, shifter_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] tgt;
  logic        at_tgt;
  logic        sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      s1_q   <= rx_if.rx;
      rx_s_q <= s1_q;
    end
  end

  // The start check samples at mid-bit; data and stop bits one full bit later each.
  assign tgt    = (state_q == StStart) ? HalfLast : BitLast;
  assign at_tgt = (cnt_q == tgt);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (cnt_q == tgt - 16'd2) vote_d[0] = rx_s_q;
    if (cnt_q == tgt - 16'd1) vote_d[1] = rx_s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_q <= 2'b11;
    end else begin
      vote_q <= vote_d;
    end
  end

  assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shifter_d   = shifter_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        cnt_d = cnt_q + 16'd1;
        if (at_tgt) begin
          cnt_d = '0;
          if (!sample) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        cnt_d = cnt_q + 16'd1;
        if (at_tgt) begin
          shifter_d = {sample, shifter_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = cnt_q + 16'd1;
        if (at_tgt) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shifter_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shifter_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shifter_q   <= shifter_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_module.sv
// Bench for uart_rx_module: table of frames plus hand sequences for glitch, framing error and reset.
// Expected strobes are queued when a frame starts and matched when valid/frame_err appears.
module tb_uart_rx_module;

  localparam int unsigned Cpb       = 16;
  localparam int unsigned Half      = Cpb / 2;
  localparam int unsigned FrameCyc  = 10 * Cpb;
  localparam int unsigned StrobeLat = 2 + Half + 9 * Cpb;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GlitchExp = 8'h96;
`else
  localparam logic [7:0] GlitchExp = 8'h69;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  last_good = 8'h00;

  uart_rx_module_if bus ();

  uart_rx_module #(.CLKS_PER_BIT(Cpb)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned when;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    bit         glitch;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line value for cycle c of a frame; c == 0 is the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] din, input logic stop, input bit glitch,
                            input int unsigned ncyc, input bit track, input logic exp_err,
                            input logic [7:0] exp_data);
    logic [9:0] bits;
    bit         flip;
    bits = {stop, din, 1'b0};
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0 && track) sb.push_back('{exp_err, exp_data, cyc + 1 + StrobeLat});
      flip = glitch && (c % Cpb == Half) && (c / Cpb >= 1) && (c / Cpb <= 8);
      bus.rx = bits[c / Cpb] ^ flip;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.valid || bus.frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected strobe", 32'({bus.valid, bus.frame_err}), 0);
      end else begin
        e = sb.pop_front();
        check("strobe kind", 32'({bus.valid, bus.frame_err}), e.err ? 32'd1 : 32'd2);
        check("strobe data", 32'(bus.data), 32'(e.data));
        check("strobe cycle", cyc, e.when);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data", 32'(bus.data), 0);
    check("reset valid", 32'(bus.valid), 0);
    check("reset frame_err", 32'(bus.frame_err), 0);
    check("reset busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81};
    vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0, GlitchExp};

    // Frames run back-to-back with no idle gap.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].din, vecs[i].stop, vecs[i].glitch, FrameCyc, 1'b1,
                 vecs[i].exp_err, vecs[i].exp_data);
      if (!vecs[i].exp_err) last_good = vecs[i].exp_data;
    end
    repeat (10) @(negedge clk);
    check("idle after frames busy", 32'(bus.busy), 0);

    // Four-cycle low glitch: START entered, rejected at the mid-bit check.
    @(negedge clk);
    bus.rx = 1'b0;
    t0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("glitch busy early", 32'(bus.busy), (k >= 2) ? 32'd1 : 32'd0);
    end
    bus.rx = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch busy at check-1", 32'(bus.busy), 1);
    check("glitch cycle sync", cyc, t0 + 9);
    @(negedge clk);
    check("glitch busy after check", 32'(bus.busy), 0);
    repeat (20) @(negedge clk);
    check("glitch stays idle", 32'(bus.busy), 0);

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, 1'b0, FrameCyc, 1'b1, 1'b1, last_good);
    repeat (50) @(negedge clk);
    check("break busy", 32'(bus.busy), 1);
    check("break data held", 32'(bus.data), 32'(last_good));
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    check("break release busy", 32'(bus.busy), 0);
    repeat (20) @(negedge clk);
    check("no start after break", 32'(bus.busy), 0);

    // Reset in the middle of data bit 4 aborts the frame silently.
    send_frame(8'h11, 1'b1, 1'b0, 5 * Cpb + Half, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    #1;
    check("midreset data", 32'(bus.data), 0);
    check("midreset valid", 32'(bus.valid), 0);
    check("midreset frame_err", 32'(bus.frame_err), 0);
    check("midreset busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    last_good = 8'h00;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, FrameCyc, 1'b1, 1'b0, 8'h5A);
    repeat (10) @(negedge clk);
    check("final data", 32'(bus.data), 32'h5A);

    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    check("pending strobes", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
# uart_rx_module

Serial receiver for 8-N-1 UART frames: LSB first, idle-high line, one stop bit, same `CLKS_PER_BIT` convention as the team's transmitter. It sits between the external `rx` pin and the byte-level logic, and delivers each received byte with a one-cycle `valid` strobe. It synchronises the asynchronous line, rejects start-bit glitches and flags framing errors.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per bit (Fclk/Baud).
  - Legal range: 4..65535, or 8..65535 with `UART_RX_MAJORITY_EN`.
  - `HALF` = `CLKS_PER_BIT/2`, rounded down.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx`  in  1: asynchronous serial line, idles at 1.
- `data`  out  8: last correctly framed byte; holds its value until the next good frame.
- `valid`  out  1: one-cycle pulse when `data` has been updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled as 0.
- `busy`  out  1: high while the receiver is in any state other than IDLE.

## Operation
- Synchroniser: two flops, `rx` → `s1` → `rx_s`. Both reset to 1. The FSM reads only `rx_s`.
- Internal registers: 16-bit `cnt`, 3-bit `bit_idx`, 8-bit `shifter`.
- States are IDLE, START, DATA, STOP and WAIT_HIGH.
- IDLE:
  - `cnt`=0 and `busy`=0.
  - If `rx_s`=0, go to START with `cnt`=0.
- START:
  - `cnt` increments each cycle.
  - At `cnt`==`HALF`-1, sample `rx_s`:
    - 0: go to DATA with `cnt`=0 and `bit_idx`=0.
    - 1: glitch; return to IDLE. No output strobe.
- DATA:
  - `cnt` increments each cycle.
  - At `cnt`==`CLKS_PER_BIT`-1, sample `rx_s` into `shifter` as `{sample, shifter[7:1]}`, set `cnt`=0 and increment `bit_idx`.
  - After the sample with `bit_idx`==7, go to STOP.
- STOP:
  - At `cnt`==`CLKS_PER_BIT`-1, sample `rx_s`:
    - 1: `data`<=`shifter`, pulse `valid`, go to IDLE.
    - 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s`=1, then go to IDLE.
  - A break condition therefore never re-triggers a start.
- `valid` and `frame_err` are registered, mutually exclusive, and never high for two consecutive cycles.
- Overruns are not detected. The consumer must take `data` within one frame time.
- Unreachable state encodings go to IDLE.

## Timing
- Reset values:
  - Outputs: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0.
  - Internal: state IDLE, `cnt`=0, `bit_idx`=0, `shifter`=0.
- Reset asserted mid-frame aborts the frame immediately with no strobe. After release, reception resumes at the next falling edge of `rx_s`.
- Latency: let e0 be the first rising edge at which `rx` is 0.
  - START is entered at e2.
  - The start check happens at e(2+`HALF`).
  - Data bit k is sampled at e(2+`HALF`+(k+1)·`CLKS_PER_BIT`).
  - The stop bit is sampled at e(2+`HALF`+9·`CLKS_PER_BIT`). `valid`/`frame_err` are high for the cycle that follows this edge.
  - With the default parameter this is e154.
- `busy` rises at e2 and falls in the same cycle that `valid`/`frame_err` rises, or when a rejected glitch returns to IDLE. After a frame error, `busy` stays high through WAIT_HIGH.
- Back-to-back frames: the STOP→IDLE transition happens at mid-stop-bit. The next start edge is therefore caught with at most 1 cycle of extra skew.

## Configuration
- `UART_RX_MAJORITY_EN` defined: 3-sample majority vote.
  - Each sampled bit (start check, data, stop) is the 2-of-3 majority of `rx_s` at `cnt`==T-2, T-1 and T. T is the normal sample count value.
  - The two earlier samples are stored in a 2-bit register.
  - The decision edge is unchanged, so latency is unchanged.
- Macro not defined: single sample at `cnt`==T, and no vote register exists.

## Test plan
- Reset, then send 0xA5 at `CLKS_PER_BIT`=16 → `data`=0xA5, `valid` high exactly one cycle after e154, `frame_err`=0.
- Send 0x00 and 0xFF back-to-back with no idle gap → two `valid` pulses 160 cycles apart, with `data`=0x00 then `data`=0xFF.
- Pull `rx` low for 4 cycles then high → no `valid`/`frame_err`; `busy` high from e2 through the START check, then back to 0.
- Send 0x3C with the stop bit forced to 0, and hold `rx` low for 50 more cycles → one `frame_err` pulse, `data` keeps its previous value, and no new START until `rx` returns to 1.
- Assert `rst_n` low mid-data-bit 4, then release and send 0x5A → all outputs read 0 during reset; the only strobe is `valid` with `data`=0x5A.
- With `UART_RX_MAJORITY_EN`, inject a 1-cycle inverted glitch at the mid-bit of every data bit of 0x96 → `data`=0x96 and `valid` pulses. Without the macro, the same stimulus yields 0x69.
